// File: rtl/trigger_sequencer.sv
// ---------------------------------------------------------------------------
// trigger_sequencer
//
// Produces the trigger output pulse train in the front-end clock domain. One
// sequence runs per accepted pattern match. It is made of up to
// pNUM_TRIGGER_PULSES pulses, and each pulse has its own delay and width.
// Every field is a down-counter reload value, so a value v gives v+1 cycles.
//
// Ports:
//   fe_clk                 front-end clock, sole clock of the block
//   reset_n                synchronous active-low reset
//   I_arm                  arm level (already in fe_clk); gates only the start
//   I_trigger_enable       master enable; dropping it aborts a sequence
//   I_match                pattern-match pulse from the front-end
//   I_num_triggers         requested pulses per sequence (0 -> 1, clamped)
//   I_trigger_delay        packed per-pulse delays, field i at [i*W +: W]
//   I_trigger_width        packed per-pulse widths, same packing
//   O_trigger              registered trigger output
//   O_capture_enable_pulse one-cycle pulse when a sequence starts
//   O_busy                 high while a sequence is running
//   O_pulse_index          index of the pulse currently being generated
//   O_done                 one-cycle pulse on normal completion
// ---------------------------------------------------------------------------
module trigger_sequencer #(
  parameter int pNUM_TRIGGER_PULSES = 8,
  parameter int pNUM_TRIGGER_WIDTH  = 4,
  parameter int pCNT_WIDTH          = 24
) (
  input  logic                                      fe_clk,
  input  logic                                      reset_n,
  input  logic                                      I_arm,
  input  logic                                      I_trigger_enable,
  input  logic                                      I_match,
  input  logic [pNUM_TRIGGER_WIDTH-1:0]             I_num_triggers,
  input  logic [pCNT_WIDTH*pNUM_TRIGGER_PULSES-1:0] I_trigger_delay,
  input  logic [pCNT_WIDTH*pNUM_TRIGGER_PULSES-1:0] I_trigger_width,
  output logic                                      O_trigger,
  output logic                                      O_capture_enable_pulse,
  output logic                                      O_busy,
  output logic [pNUM_TRIGGER_WIDTH-1:0]             O_pulse_index,
  output logic                                      O_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2
  } state_t;

  localparam logic [31:0] MAX_PULSES = 32'(pNUM_TRIGGER_PULSES);

  state_t                          state_reg;
  logic [pCNT_WIDTH-1:0]           count_reg;
  logic [pNUM_TRIGGER_WIDTH-1:0]   index_reg;
  logic                            trigger_reg;
  logic                            capture_reg;
  logic                            busy_reg;
  logic                            done_reg;

  // Unpacked views of the packed delay/width register fields
  logic [pCNT_WIDTH-1:0] delay_arr [pNUM_TRIGGER_PULSES];
  logic [pCNT_WIDTH-1:0] width_arr [pNUM_TRIGGER_PULSES];

  genvar gi;
  generate
    for (gi = 0; gi < pNUM_TRIGGER_PULSES; gi++) begin : g_fields
      assign delay_arr[gi] = I_trigger_delay[gi*pCNT_WIDTH +: pCNT_WIDTH];
      assign width_arr[gi] = I_trigger_width[gi*pCNT_WIDTH +: pCNT_WIDTH];
    end
  endgenerate

  // Effective pulse count: 0 means one pulse, and oversize requests clamp to
  // the number of field slots.
  logic [31:0] num_req;
  logic [31:0] n_eff;
  assign num_req = 32'(I_num_triggers);
  assign n_eff   = (num_req == 32'd0)      ? 32'd1 :
                   (num_req > MAX_PULSES)  ? MAX_PULSES : num_req;

  // The comparison is done at 32 bits so that index+1 cannot wrap.
  // ">=" instead of "==" keeps the FSM terminating when the count register
  // shrinks mid-sequence.
  logic [31:0] next_index_ext;
  logic        last_pulse;
  assign next_index_ext = 32'(index_reg) + 32'd1;
  assign last_pulse     = (next_index_ext >= n_eff);

  // Field selection uses compare-muxes, so an out-of-range index just yields 0.
  logic [pCNT_WIDTH-1:0] next_delay;
  logic [pCNT_WIDTH-1:0] cur_width;
  always_comb begin
    next_delay = '0;
    cur_width  = '0;
    for (int i = 0; i < pNUM_TRIGGER_PULSES; i++) begin
      if (next_index_ext == 32'(i)) next_delay = delay_arr[i];
      if (32'(index_reg) == 32'(i)) cur_width  = width_arr[i];
    end
  end

  logic start;
  assign start = I_match & I_arm & I_trigger_enable;

  always_ff @(posedge fe_clk) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      index_reg   <= '0;
      trigger_reg <= 1'b0;
      capture_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      capture_reg <= 1'b0;
      done_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          trigger_reg <= 1'b0;
          if (start) begin
            state_reg   <= DELAY;
            count_reg   <= delay_arr[0];
            index_reg   <= '0;
            capture_reg <= 1'b1;
            busy_reg    <= 1'b1;
          end
        end
        DELAY: begin
          if (!I_trigger_enable) begin
            state_reg   <= IDLE;
            trigger_reg <= 1'b0;
            busy_reg    <= 1'b0;
          end else if (count_reg != '0) begin
            count_reg <= count_reg - pCNT_WIDTH'(1);
          end else begin
            state_reg   <= PULSE;
            trigger_reg <= 1'b1;
            count_reg   <= cur_width;
          end
        end
        PULSE: begin
          if (!I_trigger_enable) begin
            state_reg   <= IDLE;
            trigger_reg <= 1'b0;
            busy_reg    <= 1'b0;
          end else if (count_reg != '0) begin
            count_reg <= count_reg - pCNT_WIDTH'(1);
          end else if (!last_pulse) begin
            state_reg   <= DELAY;
            trigger_reg <= 1'b0;
            index_reg   <= index_reg + pNUM_TRIGGER_WIDTH'(1);
            count_reg   <= next_delay;
          end else begin
            state_reg   <= IDLE;
            trigger_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
          end
        end
        default: begin
          state_reg   <= IDLE;
          trigger_reg <= 1'b0;
          busy_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign O_trigger              = trigger_reg;
  assign O_capture_enable_pulse = capture_reg;
  assign O_busy                 = busy_reg;
  assign O_pulse_index          = index_reg;
  assign O_done                 = done_reg;

endmodule
